// File: rtl/wb_collector.sv
// Write-back collector: buffers per-unit result streams in small FIFOs and
// round-robin arbitrates them onto NR_WB registered scoreboard write ports.
module wb_collector #(
    parameter int NR_SRC        = 5,
    parameter int NR_WB         = 2,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [NR_SRC-1:0]               src_valid_i,
    input  logic [NR_SRC*TRANS_ID_BITS-1:0] src_trans_id_i,
    input  logic [NR_SRC*XLEN-1:0]          src_result_i,
    input  logic [NR_SRC-1:0]               src_ex_valid_i,
    input  logic [NR_SRC*XLEN-1:0]          src_ex_cause_i,
    output logic [NR_SRC-1:0]               src_almost_full_o,
    output logic [NR_WB-1:0]                wb_valid_o,
    output logic [NR_WB*TRANS_ID_BITS-1:0]  wb_trans_id_o,
    output logic [NR_WB*XLEN-1:0]           wb_result_o,
    output logic [NR_WB-1:0]                wb_ex_valid_o,
    output logic [NR_WB*XLEN-1:0]           wb_ex_cause_o,
    output logic                            overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     ex_valid;
        logic [XLEN-1:0]          ex_cause;
    } entry_t;

    entry_t              in_entry [NR_SRC];
    entry_t              cand     [NR_SRC];
    logic [NR_SRC-1:0]   cand_valid;
    logic [NR_SRC-1:0]   grant;
    logic [NR_SRC-1:0]   ovf_src;
    logic [NR_SRC-1:0]   af_d, af_q;
    logic [SRC_W-1:0]    port_src [NR_WB];
    logic [NR_WB-1:0]    port_valid;
    logic [SRC_W-1:0]    rr_ptr_d, rr_ptr_q;
    logic [NR_WB-1:0]    wb_valid_q;
    entry_t              wb_entry_q [NR_WB];
    logic                overflow_q;

    // Per-source FIFO; the head (or the live input when empty) is the candidate.
    for (genvar gi = 0; gi < NR_SRC; gi++) begin : g_src
        entry_t           mem_q [DEPTH];
        logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
        logic [PTR_W:0]   cnt_d, cnt_q;
        logic             empty, full, pop, push, wr_en;

        assign in_entry[gi] = '{trans_id: src_trans_id_i[gi*TRANS_ID_BITS +: TRANS_ID_BITS],
                                result:   src_result_i[gi*XLEN +: XLEN],
                                ex_valid: src_ex_valid_i[gi],
                                ex_cause: src_ex_cause_i[gi*XLEN +: XLEN]};

        assign empty          = (cnt_q == '0);
        assign full           = (cnt_q == (PTR_W+1)'(DEPTH));
        assign cand_valid[gi] = !empty || src_valid_i[gi];
        assign cand[gi]       = empty ? in_entry[gi] : mem_q[rd_ptr_q];

        assign pop   = grant[gi] && !empty;
        assign push  = src_valid_i[gi] && !(grant[gi] && empty) && !flush_i;
        // A push into a full FIFO only succeeds when the head leaves this cycle.
        assign wr_en       = push && (!full || pop);
        assign ovf_src[gi] = push && full && !pop;

        always_comb begin
            cnt_d = cnt_q;
            if (flush_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
            end
        end

        assign af_d[gi] = (cnt_d >= (PTR_W+1)'(DEPTH-1));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (wr_en) mem_q[wr_ptr_q] <= in_entry[gi];
        end
    end

    // Walk sources in circular order from rr_ptr, granting up to NR_WB of them.
    always_comb begin
        int n;
        int idx;
        int last;
        grant      = '0;
        port_valid = '0;
        for (int k = 0; k < NR_WB; k++) port_src[k] = '0;
        n    = 0;
        last = int'(rr_ptr_q);
        for (int off = 0; off < NR_SRC; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NR_SRC) idx = idx - NR_SRC;
            if (cand_valid[idx] && n < NR_WB) begin
                grant[idx]    = 1'b1;
                port_src[n]   = SRC_W'(idx);
                port_valid[n] = 1'b1;
                last          = idx;
                n             = n + 1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (n > 0) begin
            rr_ptr_d = (last == NR_SRC-1) ? '0 : SRC_W'(last + 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            af_q       <= '0;
            wb_valid_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            af_q       <= flush_i ? '0 : af_d;
            wb_valid_q <= flush_i ? '0 : port_valid;
            overflow_q <= overflow_q || (|ovf_src);
        end
    end

    // Ungranted ports keep their last payload; only valid drops.
    for (genvar gi = 0; gi < NR_WB; gi++) begin : g_port
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wb_entry_q[gi] <= '0;
            end else if (!flush_i && port_valid[gi]) begin
                wb_entry_q[gi] <= cand[port_src[gi]];
            end
        end

        assign wb_trans_id_o[gi*TRANS_ID_BITS +: TRANS_ID_BITS] = wb_entry_q[gi].trans_id;
        assign wb_result_o[gi*XLEN +: XLEN]                     = wb_entry_q[gi].result;
        assign wb_ex_valid_o[gi]                                = wb_entry_q[gi].ex_valid;
        assign wb_ex_cause_o[gi*XLEN +: XLEN]                   = wb_entry_q[gi].ex_cause;
    end

    assign wb_valid_o        = wb_valid_q;
    assign src_almost_full_o = af_q;
    assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_wb_collector.sv
// Bench for wb_collector: per-cycle vector table with hand-derived port/flag
// expectations, plus a per-source payload queue checking order and contents.
module tb_wb_collector;

    localparam int NS = 5;
    localparam int NW = 2;
    localparam int XL = 64;
    localparam int TB = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic [NS-1:0]     src_valid_i;
    logic [NS*TB-1:0]  src_trans_id_i;
    logic [NS*XL-1:0]  src_result_i;
    logic [NS-1:0]     src_ex_valid_i;
    logic [NS*XL-1:0]  src_ex_cause_i;
    logic [NS-1:0]     src_almost_full_o;
    logic [NW-1:0]     wb_valid_o;
    logic [NW*TB-1:0]  wb_trans_id_o;
    logic [NW*XL-1:0]  wb_result_o;
    logic [NW-1:0]     wb_ex_valid_o;
    logic [NW*XL-1:0]  wb_ex_cause_o;
    logic              overflow_o;

    wb_collector #(.NR_SRC(NS), .NR_WB(NW), .XLEN(XL), .TRANS_ID_BITS(TB), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .src_valid_i(src_valid_i), .src_trans_id_i(src_trans_id_i),
        .src_result_i(src_result_i), .src_ex_valid_i(src_ex_valid_i),
        .src_ex_cause_i(src_ex_cause_i), .src_almost_full_o(src_almost_full_o),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
        .wb_result_o(wb_result_o), .wb_ex_valid_o(wb_ex_valid_o),
        .wb_ex_cause_o(wb_ex_cause_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  valid;
        logic [4:0]  ex;
        logic        flush;
        logic [2:0]  base;
        logic [63:0] res0;
        logic [4:0]  drop;
        logic [1:0]  wbv;
        logic [2:0]  id0;
        logic [2:0]  id1;
        logic [4:0]  af;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [2:0]  tid;
        logic [63:0] res;
        logic        ex;
        logic [63:0] cause;
    } pl_t;

    vec_t vecs [26];
    pl_t  sq [NS][$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [4:0] valid, logic [4:0] ex, logic flush, logic [2:0] base,
                                logic [63:0] res0, logic [4:0] drop, logic [1:0] wbv,
                                logic [2:0] id0, logic [2:0] id1, logic [4:0] af, logic ovf);
        vec_t v;
        v.valid = valid; v.ex = ex; v.flush = flush; v.base = base; v.res0 = res0;
        v.drop = drop; v.wbv = wbv; v.id0 = id0; v.id1 = id1; v.af = af; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pl_t p;
        if (v.flush) for (int s = 0; s < NS; s++) sq[s].delete();
        flush_i = v.flush;
        for (int s = 0; s < NS; s++) begin
            p.tid   = 3'(v.base + 3'(s));
            p.res   = (s == 0 && v.res0 != 0) ? v.res0 : {$urandom, $urandom};
            p.ex    = v.ex[s];
            p.cause = v.ex[s] ? 64'(4 + s) : {$urandom, $urandom};
            src_valid_i[s]             = v.valid[s];
            src_trans_id_i[s*TB +: TB] = p.tid;
            src_result_i[s*XL +: XL]   = p.res;
            src_ex_valid_i[s]          = p.ex;
            src_ex_cause_i[s*XL +: XL] = p.cause;
            if (v.valid[s] && !v.flush && !v.drop[s]) sq[s].push_back(p);
        end
    endtask

    // Every valid write port must equal the oldest outstanding entry of some source.
    task automatic score(input int vi);
        pl_t got;
        bit  hit;
        for (int k = 0; k < NW; k++) begin
            if (wb_valid_o[k]) begin
                got = '{wb_trans_id_o[k*TB +: TB], wb_result_o[k*XL +: XL],
                        wb_ex_valid_o[k], wb_ex_cause_o[k*XL +: XL]};
                hit = 1'b0;
                for (int s = 0; s < NS; s++) begin
                    if (!hit && sq[s].size() > 0 && sq[s][0] == got) begin
                        void'(sq[s].pop_front());
                        hit = 1'b1;
                    end
                end
                checks++;
                if (!hit) begin
                    errors++;
                    $display("FAIL payload vec%0d port%0d: got tid=%0d res=%0h ex=%0b cause=%0h, required head of a source queue",
                             vi, k, got.tid, got.res, got.ex, got.cause);
                end
            end
        end
    endtask

    initial begin
        // valid ex flush base res0 drop | wbv id0 id1 af ovf
        vecs[0]  = mk(5'b00001, 5'b00000, 0, 3, 64'hDEAD, 0, 2'b01, 3, 0, 5'b00000, 0); // single FLU
        vecs[1]  = mk(5'b00010, 5'b00010, 0, 2, 0, 0, 2'b01, 3, 0, 5'b00000, 0);        // load exception
        vecs[2]  = mk(5'b00000, 5'b00000, 1, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 0);        // flush -> rr=0
        vecs[3]  = mk(5'b11111, 5'b00000, 0, 0, 0, 0, 2'b11, 0, 1, 5'b11100, 0);       // contention
        vecs[4]  = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b11, 2, 3, 5'b10000, 0);
        vecs[5]  = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b01, 4, 0, 5'b00000, 0);
        vecs[6]  = mk(5'b00111, 5'b00000, 0, 0, 0, 0, 2'b11, 0, 1, 5'b00100, 0);       // fairness
        vecs[7]  = mk(5'b00011, 5'b00000, 0, 5, 0, 0, 2'b11, 2, 5, 5'b00010, 0);
        vecs[8]  = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b01, 6, 0, 5'b00000, 0);
        vecs[9]  = mk(5'b00000, 5'b00000, 1, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 0);
        vecs[10] = mk(5'b01000, 5'b00000, 0, 0, 0, 0, 2'b01, 3, 0, 5'b00000, 0);       // rr -> 4
        vecs[11] = mk(5'b11001, 5'b00000, 0, 0, 0, 0, 2'b11, 4, 0, 5'b01000, 0);       // FPU buffered
        vecs[12] = mk(5'b01110, 5'b00000, 0, 4, 0, 0, 2'b11, 5, 6, 5'b01000, 0);       // FPU holds 2
        vecs[13] = mk(5'b00000, 5'b00000, 1, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 0);       // flush them
        vecs[14] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 0);
        vecs[15] = mk(5'b11111, 5'b00000, 0, 0, 0, 0, 2'b11, 0, 1, 5'b11100, 0);       // saturate
        vecs[16] = mk(5'b11111, 5'b00000, 0, 5, 0, 0, 2'b11, 2, 3, 5'b11111, 0);
        vecs[17] = mk(5'b11111, 5'b00000, 0, 2, 0, 0, 2'b11, 4, 5, 5'b11111, 0);
        vecs[18] = mk(5'b11111, 5'b00000, 0, 7, 0, 5'b11000, 2'b11, 6, 7, 5'b11111, 1); // drops
        vecs[19] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b11, 0, 1, 5'b11111, 1);       // drain
        vecs[20] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b11, 2, 3, 5'b11111, 1);
        vecs[21] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b11, 4, 5, 5'b10111, 1);
        vecs[22] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b11, 6, 7, 5'b00110, 1);
        vecs[23] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b11, 0, 1, 5'b00000, 1);
        vecs[24] = mk(5'b00000, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 1);
        vecs[25] = mk(5'b00000, 5'b00000, 1, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 1);       // sticky ovf

        rst_ni = 1'b0;
        flush_i = 1'b0;
        src_valid_i = '0;
        src_trans_id_i = '0;
        src_result_i = '0;
        src_ex_valid_i = '0;
        src_ex_cause_i = '0;
        #12;
        chk("reset wb_valid", 64'(wb_valid_o), 64'h0);
        chk("reset wb_trans_id", 64'(wb_trans_id_o), 64'h0);
        chk("reset wb_result0", wb_result_o[63:0], 64'h0);
        chk("reset wb_ex_valid", 64'(wb_ex_valid_o), 64'h0);
        chk("reset wb_ex_cause0", wb_ex_cause_o[63:0], 64'h0);
        chk("reset almost_full", 64'(src_almost_full_o), 64'h0);
        chk("reset overflow", 64'(overflow_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            @(posedge clk_i);
            #1;
            $display("vec %0d: valid_in=%b flush=%0b -> wb_valid=%b ids=%0d,%0d af=%b ovf=%0b",
                     i, vecs[i].valid, vecs[i].flush, wb_valid_o, wb_trans_id_o[2:0],
                     wb_trans_id_o[5:3], src_almost_full_o, overflow_o);
            chk($sformatf("vec%0d wb_valid", i), 64'(wb_valid_o), 64'(vecs[i].wbv));
            if (vecs[i].wbv[0]) chk($sformatf("vec%0d id0", i), 64'(wb_trans_id_o[2:0]), 64'(vecs[i].id0));
            if (vecs[i].wbv[1]) chk($sformatf("vec%0d id1", i), 64'(wb_trans_id_o[5:3]), 64'(vecs[i].id1));
            chk($sformatf("vec%0d almost_full", i), 64'(src_almost_full_o), 64'(vecs[i].af));
            chk($sformatf("vec%0d overflow", i), 64'(overflow_o), 64'(vecs[i].ovf));
            score(i);
        end

        for (int s = 0; s < NS; s++)
            chk($sformatf("src%0d leftover entries", s), 64'(sq[s].size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_collector.md
Name: wb_collector

Overview:
- Receiving end of the execute-stage write-back interface.
- Takes per-unit result streams (FLU, load, store, FPU, CV-X-IF), each a valid/trans_id/result/exception tuple with no ready back-channel.
- Buffers them per source and arbitrates them onto NR_WB registered scoreboard write ports.
- Sits between ex_stage and the scoreboard. Gives issue logic per-source almost-full back-pressure so no result is lost.

Parameters:
- NR_SRC, 5, number of result sources (0=FLU, 1=load, 2=store, 3=FPU, 4=X).
- NR_WB, 2, number of scoreboard write ports (1..NR_SRC).
- XLEN, 64, result and exception-cause width.
- TRANS_ID_BITS, 3, scoreboard transaction ID width.
- DEPTH, 2, per-source FIFO depth (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered and in-flight results
- src_valid_i  in  NR_SRC  result valid per source
- src_trans_id_i  in  NR_SRC*TRANS_ID_BITS  scoreboard ID per source
- src_result_i  in  NR_SRC*XLEN  result per source
- src_ex_valid_i  in  NR_SRC  exception flag per source
- src_ex_cause_i  in  NR_SRC*XLEN  exception cause per source
- src_almost_full_o  out  NR_SRC  FIFO occupancy >= DEPTH-1; issue must not dispatch to that unit
- wb_valid_o  out  NR_WB  write-port valid
- wb_trans_id_o  out  NR_WB*TRANS_ID_BITS  write-port ID
- wb_result_o  out  NR_WB*XLEN  write-port data
- wb_ex_valid_o  out  NR_WB  write-port exception flag
- wb_ex_cause_o  out  NR_WB*XLEN  write-port exception cause
- overflow_o  out  1  sticky error: push into a full FIFO

Behaviour:
- Reset (async, rst_ni=0):
  - All FIFOs empty; rr_ptr=0.
  - wb_valid_o=0, wb_trans_id_o=0, wb_result_o=0, wb_ex_valid_o=0, wb_ex_cause_o=0.
  - src_almost_full_o=0, overflow_o=0.
- Per-source candidate each cycle: FIFO head if non-empty, else the live input if src_valid_i (bypass). Per-source order is strictly preserved.
- Arbitration:
  - Round-robin from rr_ptr.
  - Grant up to NR_WB candidates, in ascending circular source order starting at rr_ptr.
  - Grant k is placed on write port k.
  - Next cycle rr_ptr = (last granted source + 1) mod NR_SRC; unchanged if nothing is granted.
- Output registers:
  - Granted entries are registered into wb_* at the clock edge.
  - Minimum latency is 1 cycle (input at t visible on wb at t+1).
  - Ports not granted have wb_valid_o=0; their data holds its previous value.
  - The scoreboard always accepts, so there is no wb ready.
- FIFO update per source per cycle:
  - Pop if the head was granted.
  - Push input if src_valid_i and it was not consumed by bypass.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Push while full with no pop: entry dropped, overflow_o set, and stays set until reset.
- src_almost_full_o is registered: it reflects occupancy after the cycle's update, >= DEPTH-1.
- flush_i=1:
  - At the edge, all FIFOs are emptied, inputs of that cycle are discarded, wb_valid_o is cleared, and rr_ptr=0.
  - wb_valid_o is 0 in the cycle after flush.
  - overflow_o is unaffected.
- Pointer arithmetic:
  - log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- Payload (trans_id, result, ex_valid, ex_cause) is passed through unmodified; no width conversion.

Test Plan:
- Single result: FLU valid, trans_id=3, result=0xDEAD → next cycle wb_valid_o=01, port0 trans_id=3, result=0xDEAD; rr_ptr=1.
- Contention: all 5 sources valid at t, IDs 0..4, rr_ptr=0 → t+1 ports carry IDs 0,1; t+2 IDs 2,3; t+3 ID 4 on port0, port1 invalid. src_almost_full_o asserted for sources 2-4 after t.
- Fairness: load and store continuously valid with NR_WB=1 → grants alternate load/store every cycle; no starvation.
- Overflow: store valid for 4 consecutive cycles while FLU/load/FPU/X saturate the ports with rr_ptr stalled → the third unserviced push sets overflow_o=1; the dropped entry never appears on wb.
- Flush: two entries buffered in the FPU FIFO, flush_i pulsed → next cycle wb_valid_o=0, the FIFO is empty, and those IDs never appear on wb.
- Exception pass-through: load valid, ex_valid=1, cause=0x5 → wb_ex_valid_o=1, wb_ex_cause_o=0x5, same trans_id.
